// File: rtl/temp_sensor_pkg.sv
// Shared constants for the temperature-sensor-to-FIFO bridge.
//   TS_DATA_W    : width of one temperature reading
//   TS_VALID_BIT : position of the reading-valid flag inside din_sensor
package temp_sensor_pkg;
  localparam int TS_DATA_W    = 8;
  localparam int TS_VALID_BIT = TS_DATA_W;
endpackage

// File: rtl/temp_sensor.sv
// Bridge between a digital temperature sensor and the sample FIFO.
// Asks the sensor for a new reading whenever the FIFO has room. It then
// captures each valid reading that arrives while the FIFO is not full.
// Ports:
//   clk          in  system clock, rising edge
//   reset        in  synchronous active-low reset
//   fifo_full    in  downstream FIFO full flag
//   din_sensor   in  {valid, reading[DATA_W-1:0]}
//   data_to_fifo out last accepted reading (registered)
//   dout_sensor  out read request to sensor (registered)
module temp_sensor
  import temp_sensor_pkg::*;
#(
  parameter int DATA_W = TS_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_full,
  input  logic [DATA_W:0]   din_sensor,
  output logic [DATA_W-1:0] data_to_fifo,
  output logic              dout_sensor
);

  localparam int VALID_BIT = DATA_W;

  // A reading that arrives while the FIFO is full is dropped, not held.
  // The request falls on the next edge, so the sensor stops sending.
  logic take;
  assign take = din_sensor[VALID_BIT] & ~fifo_full;

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_to_fifo <= '0;
      dout_sensor  <= 1'b0;
    end else begin
      dout_sensor <= ~fifo_full;
      if (take) data_to_fifo <= din_sensor[DATA_W-1:0];
    end
  end

endmodule

// File: tb/tb_temp_sensor.sv
module tb_temp_sensor;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         fifo_full;
  logic [W:0]   din_sensor;
  logic [W-1:0] data_to_fifo;
  logic         dout_sensor;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model. It keeps the history of accepted readings, and the
  // output shows the newest one. The request flag mirrors the FIFO room
  // that was seen at the last edge.
  logic [W-1:0] accepted_q[$];
  logic         exp_req;

  temp_sensor #(.DATA_W(W)) dut (
    .clk(clk), .reset(reset), .fifo_full(fifo_full),
    .din_sensor(din_sensor), .data_to_fifo(data_to_fifo),
    .dout_sensor(dout_sensor)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_data();
    return (accepted_q.size() == 0) ? '0 : accepted_q[$];
  endfunction

  // Drive on the falling edge, let one rising edge pass, then update the model
  // and compare 1 ns later.
  task automatic step(input logic rst_n, input logic full, input logic [W:0] din,
                      input string tag);
    @(negedge clk);
    reset = rst_n; fifo_full = full; din_sensor = din;
    @(posedge clk);
    if (!rst_n) begin
      accepted_q.delete();
      exp_req = 1'b0;
    end else begin
      exp_req = !full;
      if (din[W] && !full) accepted_q.push_back(din[W-1:0]);
      if (accepted_q.size() > 64) void'(accepted_q.pop_front());
    end
    #1;
    chk({tag, ".data"}, 32'(data_to_fifo), 32'(exp_data()));
    chk({tag, ".req"},  32'(dout_sensor),  32'(exp_req));
  endtask

  initial begin
    reset = 1'b0; fifo_full = 1'b0; din_sensor = 9'h1FF;
    exp_req = 1'b0;

    // 1: reset overrides a valid reading
    repeat (3) step(1'b0, 1'b0, 9'h1FF, "reset");
    chk("reset_const.data", 32'(data_to_fifo), 32'h00);
    chk("reset_const.req",  32'(dout_sensor),  32'h0);

    // 2: capture
    step(1'b1, 1'b0, 9'h13C, "capture");
    chk("capture_const", 32'(data_to_fifo), 32'h3C);
    // 3: invalid data ignored
    step(1'b1, 1'b0, 9'h0AA, "invalid");
    chk("invalid_const", 32'(data_to_fifo), 32'h3C);
    // 4: FIFO full drops the reading, then it is accepted
    step(1'b1, 1'b1, 9'h155, "full");
    chk("full_const.data", 32'(data_to_fifo), 32'h3C);
    chk("full_const.req",  32'(dout_sensor),  32'h0);
    step(1'b1, 1'b0, 9'h155, "unfull");
    chk("unfull_const", 32'(data_to_fifo), 32'h55);
    // 5: streaming
    step(1'b1, 1'b0, 9'h101, "stream0");
    chk("stream0_const", 32'(data_to_fifo), 32'h01);
    step(1'b1, 1'b0, 9'h102, "stream1");
    chk("stream1_const", 32'(data_to_fifo), 32'h02);
    step(1'b1, 1'b0, 9'h1FF, "stream2");
    chk("stream2_const", 32'(data_to_fifo), 32'hFF);
    // 6: mid-run reset
    step(1'b1, 1'b0, 9'h155, "pre_rst");
    step(1'b0, 1'b0, 9'h1AA, "mid_rst");
    chk("mid_rst_const.data", 32'(data_to_fifo), 32'h00);
    chk("mid_rst_const.req",  32'(dout_sensor),  32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic r, f;
      logic [W:0] d;
      r = ($urandom_range(0, 19) != 0);
      f = ($urandom_range(0, 2) == 0);
      d = W'(0) + (W+1)'($urandom);
      step(r, f, d, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
